margin_calc: RTL and testbench

MARGIN_CALC -- requirements
Module: margin_calc

---
 rtl/margin_calc_if.sv | 39 +++
 rtl/margin_calc.sv | 131 +++++++++++++
 tb/tb_margin_calc.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/margin_calc_if.sv
// rtl/margin_calc_if.sv - margin_calc control, score and result bundle
// out_class exists only when MARGIN_CALC_ARGMAX_EN is defined.
interface margin_calc_if #(
   parameter int IDX_W = 13
);
   logic             start;
   logic [IDX_W-1:0] num_samples;
   logic             in_valid;
   logic             in_ready;
   logic [255:0]     in_data;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_margin;
   logic [IDX_W-1:0] out_index;
   logic             out_last;
   logic             busy;
   logic             done;
`ifdef MARGIN_CALC_ARGMAX_EN
   logic [3:0]       out_class;

   modport master (
      output start, num_samples, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_margin, out_index, out_last, busy, done, out_class
   );
   modport slave (
      input  start, num_samples, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_margin, out_index, out_last, busy, done, out_class
   );
`else
   modport master (
      output start, num_samples, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_margin, out_index, out_last, busy, done
   );
   modport slave (
      input  start, num_samples, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_margin, out_index, out_last, busy, done
   );
`endif
endinterface

// File: rtl/margin_calc.sv
// rtl/margin_calc.sv - per-beat top-1 minus top-2 score margin, 2-stage stallable pipeline
// Define MARGIN_CALC_ARGMAX_EN to add out_class (lane of the top score, lowest lane on ties).
module margin_calc #(
   parameter int NUM_CLASSES = 4,
   parameter int IDX_W       = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   margin_calc_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] num_q, cnt_q;
   logic             s1_valid_q, s1_last_q;
   logic [15:0]      s1_margin_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic             out_valid_q, out_last_q;
   logic [15:0]      out_margin_q;
   logic [IDX_W-1:0] out_index_q;
   logic             advance, accept, last_beat;
   logic             in_ready_w, busy_w, done_w;
   logic [15:0]      max1, max2;
`ifdef MARGIN_CALC_ARGMAX_EN
   logic [3:0]       max1_cls, s1_cls_q, out_class_q;
`endif
   logic             unused_upper_lanes;

   // Whole pipeline stalls together; only a held result blocks it.
   assign advance   = !out_valid_q || bus.out_ready;
   assign accept    = bus.in_valid && in_ready_w;
   assign last_beat = (cnt_q == num_q - ONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = (bus.num_samples == '0) ? DONE : RUN;
         RUN:     if (accept && last_beat) state_d = DRAIN;
         DRAIN:   if (out_valid_q && bus.out_ready && out_last_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_w = (state_q == RUN) && (cnt_q < num_q) && advance;
      busy_w     = (state_q == RUN) || (state_q == DRAIN);
      done_w     = (state_q == DONE);
   end

   // Strict '>' keeps the earlier lane as max1 on ties, pushing the equal value into max2.
   always_comb begin
      max1 = bus.in_data[15:0];
      max2 = '0;
`ifdef MARGIN_CALC_ARGMAX_EN
      max1_cls = '0;
`endif
      for (int k = 1; k < NUM_CLASSES; k++) begin
         if (bus.in_data[16*k +: 16] > max1) begin
            max2 = max1;
            max1 = bus.in_data[16*k +: 16];
`ifdef MARGIN_CALC_ARGMAX_EN
            max1_cls = 4'(k);
`endif
         end else if (bus.in_data[16*k +: 16] > max2) begin
            max2 = bus.in_data[16*k +: 16];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         num_q        <= '0;
         cnt_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_margin_q  <= '0;
         s1_idx_q     <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_margin_q <= '0;
         out_index_q  <= '0;
`ifdef MARGIN_CALC_ARGMAX_EN
         s1_cls_q     <= '0;
         out_class_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.start) begin
            num_q <= bus.num_samples;
            cnt_q <= '0;
         end else if (accept) begin
            cnt_q <= cnt_q + ONE;
         end
         if (advance) begin
            s1_valid_q  <= accept;
            out_valid_q <= s1_valid_q;
            if (accept) begin
               s1_margin_q <= max1 - max2;
               s1_idx_q    <= cnt_q;
               s1_last_q   <= last_beat;
`ifdef MARGIN_CALC_ARGMAX_EN
               s1_cls_q    <= max1_cls;
`endif
            end
            if (s1_valid_q) begin
               out_margin_q <= s1_margin_q;
               out_index_q  <= s1_idx_q;
               out_last_q   <= s1_last_q;
`ifdef MARGIN_CALC_ARGMAX_EN
               out_class_q  <= s1_cls_q;
`endif
            end
         end
      end
   end

   assign bus.in_ready   = in_ready_w;
   assign bus.busy       = busy_w;
   assign bus.done       = done_w;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_margin = out_margin_q;
   assign bus.out_index  = out_index_q;
   assign bus.out_last   = out_last_q;
`ifdef MARGIN_CALC_ARGMAX_EN
   assign bus.out_class  = out_class_q;
`endif
   assign unused_upper_lanes = ^bus.in_data;
endmodule

// File: tb/tb_margin_calc.sv
// tb/tb_margin_calc.sv - scoreboard bench for margin_calc; checks out_class when MARGIN_CALC_ARGMAX_EN is defined
module tb_margin_calc;
   localparam int NC = 4;
   localparam int IW = 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   margin_calc_if #(.IDX_W(IW)) mif ();
   margin_calc #(.NUM_CLASSES(NC), .IDX_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));

   typedef struct {
      logic [15:0]   margin;
      logic [IW-1:0] idx;
      logic          last;
      logic [3:0]    cls;
      int            acc;
   } exp_t;

   exp_t          sbq[$];
   logic [255:0]  dir_q[$];
   exp_t          mon_e;
   int            vectors = 0, miscompares = 0;
   int            rcv = 0, done_cnt = 0, run_len = 0, max_run = 0, cyc_cnt = 0;
   bit            lat_mode = 1'b0, expect_zero = 1'b0, stall_prev = 1'b0, last_xfer_prev = 1'b0;
   logic [15:0]   h_margin;
   logic [IW-1:0] h_idx;
   logic          h_last;
   logic [3:0]    h_cls;
   bit            ok;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [255:0] mk(input logic [15:0] l3, l2, l1, l0, input logic [15:0] up);
      return {{12{up}}, l3, l2, l1, l0};
   endfunction

   // Reference: argmax first (lowest lane wins), then max over every other lane.
   function automatic exp_t model(input logic [255:0] d, input int idx, input int n, input int acc);
      exp_t e;
      int a = 0;
      logic [15:0] m1, m2;
      m1 = d[15:0];
      m2 = 16'd0;
      for (int k = 1; k < NC; k++) if (d[16*k +: 16] > m1) begin m1 = d[16*k +: 16]; a = k; end
      for (int k = 0; k < NC; k++) if (k != a && d[16*k +: 16] > m2) m2 = d[16*k +: 16];
      e.margin = m1 - m2;
      e.idx    = IW'(idx);
      e.last   = (idx == n - 1);
      e.cls    = 4'(a);
      e.acc    = acc;
      return e;
   endfunction

   function automatic logic [3:0] obs_cls();
`ifdef MARGIN_CALC_ARGMAX_EN
      return mif.out_class;
`else
      return 4'd0;
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
         last_xfer_prev = 1'b0;
         run_len = 0;
      end else begin
         if (stall_prev) begin
            vectors++;
            ok = mif.out_valid === 1'b1 && mif.out_margin === h_margin && mif.out_index === h_idx && mif.out_last === h_last;
`ifdef MARGIN_CALC_ARGMAX_EN
            ok = ok && mif.out_class === h_cls;
`endif
            assert (ok) else begin
               miscompares++;
               $error("FAIL stall_hold observed v=%0b m=%0d i=%0d l=%0b expected v=1 m=%0d i=%0d l=%0b",
                      mif.out_valid, mif.out_margin, mif.out_index, mif.out_last, h_margin, h_idx, h_last);
            end
         end
         if (mif.done) begin
            done_cnt++;
            vectors++;
            assert (last_xfer_prev || expect_zero) else begin
               miscompares++;
               $error("FAIL done_timing observed done=1 expected done only right after the out_last transfer");
            end
         end
         last_xfer_prev = 1'b0;
         if (mif.out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else run_len = 0;
         if (mif.out_valid && mif.out_ready) begin
            vectors++;
            assert (sbq.size() != 0) else begin
               miscompares++;
               $error("FAIL spurious_result observed index=%0d expected no result", mif.out_index);
            end
            if (sbq.size() != 0) begin
               mon_e = sbq.pop_front();
               ok = mif.out_margin === mon_e.margin && mif.out_index === mon_e.idx && mif.out_last === mon_e.last;
`ifdef MARGIN_CALC_ARGMAX_EN
               ok = ok && mif.out_class === mon_e.cls;
`endif
               vectors++;
               assert (ok) else begin
                  miscompares++;
                  $error("FAIL result observed m=%0d i=%0d l=%0b c=%0d expected m=%0d i=%0d l=%0b c=%0d",
                         mif.out_margin, mif.out_index, mif.out_last, obs_cls(),
                         mon_e.margin, mon_e.idx, mon_e.last, mon_e.cls);
               end
               if (lat_mode) begin
                  vectors++;
                  assert (cyc_cnt - mon_e.acc == 2) else begin
                     miscompares++;
                     $error("FAIL latency observed %0d expected 2", cyc_cnt - mon_e.acc);
                  end
               end
            end
            rcv++;
            last_xfer_prev = mif.out_last;
         end
         stall_prev = mif.out_valid && !mif.out_ready;
         h_margin = mif.out_margin;
         h_idx    = mif.out_index;
         h_last   = mif.out_last;
         h_cls    = obs_cls();
      end
   end

   task automatic run_frame(input int n, input bit rnd, input int restart_at, input int abort_after);
      int sent = 0;
      int base = rcv;
      int base_done = done_cnt;
      int cyc = 0;
      bit restarted = 1'b0, chk_ir = 1'b0, need_new = 1'b1;
      logic [255:0] d = '0;
      lat_mode = !rnd;
      expect_zero = (n == 0);
      mif.num_samples = IW'(n);
      mif.start = 1'b1;
      mif.in_valid = 1'b0;
      mif.out_ready = 1'b1;
      @(posedge clk); #1;
      mif.start = 1'b0;
      while ((rcv - base) < n && cyc < 40000 && !(abort_after > 0 && (rcv - base) >= abort_after)) begin
         mif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         mif.start = 1'b0;
         if (restart_at > 0 && sent == restart_at && !restarted) begin
            mif.start = 1'b1;
            mif.num_samples = IW'(2);
            restarted = 1'b1;
         end
         if (sent < n) begin
            if (need_new) begin
               if (dir_q.size() > 0) d = dir_q.pop_front();
               else for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom();
               need_new = 1'b0;
            end
            mif.in_valid = 1'b1;
            mif.in_data = d;
         end else mif.in_valid = 1'b0;
         @(negedge clk);
         if (cyc == 0) begin
            vectors++;
            assert (mif.busy === 1'b1) else begin
               miscompares++;
               $error("FAIL busy_run observed %0b expected 1", mif.busy);
            end
         end
         if (chk_ir) begin
            vectors++;
            assert (mif.in_ready === 1'b0) else begin
               miscompares++;
               $error("FAIL in_ready_after_last observed %0b expected 0", mif.in_ready);
            end
            chk_ir = 1'b0;
         end
         if (mif.in_valid && mif.in_ready) begin
            sbq.push_back(model(d, sent, n, cyc_cnt));
            sent++;
            need_new = 1'b1;
            if (sent == n) chk_ir = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      mif.in_valid = 1'b0;
      mif.start = 1'b0;
      mif.out_ready = 1'b1;
      vectors++;
      assert (cyc < 40000) else begin
         miscompares++;
         $error("FAIL frame_timeout observed %0d results expected %0d", rcv - base, n);
      end
      if (abort_after == 0) begin
         repeat (3) @(posedge clk);
         #1;
         vectors++;
         assert (done_cnt - base_done == 1) else begin
            miscompares++;
            $error("FAIL done_count observed %0d expected 1", done_cnt - base_done);
         end
         vectors++;
         assert (mif.busy === 1'b0 && sbq.size() == 0 && rcv - base == n) else begin
            miscompares++;
            $error("FAIL frame_end observed busy=%0b pending=%0d results=%0d expected busy=0 pending=0 results=%0d",
                   mif.busy, sbq.size(), rcv - base, n);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      ok = mif.out_valid === 1'b0 && mif.in_ready === 1'b0 && mif.busy === 1'b0 && mif.done === 1'b0 &&
           mif.out_margin === 16'd0 && mif.out_index === '0 && mif.out_last === 1'b0;
`ifdef MARGIN_CALC_ARGMAX_EN
      ok = ok && mif.out_class === 4'd0;
`endif
      vectors++;
      assert (ok) else begin
         miscompares++;
         $error("FAIL %s observed v=%0b r=%0b b=%0b d=%0b m=%0d i=%0d l=%0b expected all 0", tag,
                mif.out_valid, mif.in_ready, mif.busy, mif.done, mif.out_margin, mif.out_index, mif.out_last);
      end
   endtask

   initial begin
      mif.start = 1'b0;
      mif.num_samples = '0;
      mif.in_valid = 1'b0;
      mif.in_data = '0;
      mif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst_n = 1'b1;

      dir_q.push_back(mk(16'd0, 16'd200, 16'd197, 16'd140, 16'd0));
      run_frame(1, 1'b0, 0, 0);

      dir_q.push_back(mk(16'd0, 16'd200, 16'd200, 16'd14, 16'd0));
      dir_q.push_back(mk(16'd250, 16'd2, 16'd245, 16'd28, 16'd0));
      dir_q.push_back(mk(16'd0, 16'd200, 16'd200, 16'd14, 16'hFFFF));
      dir_q.push_back(mk(16'd250, 16'd2, 16'd245, 16'd28, 16'hFFFF));
      run_frame(4, 1'b0, 0, 0);

      max_run = 0;
      run_frame(8, 1'b0, 0, 0);
      vectors++;
      assert (max_run == 8) else begin
         miscompares++;
         $error("FAIL throughput observed %0d consecutive out_valid expected 8", max_run);
      end

      run_frame(6, 1'b0, 3, 0);
      run_frame(0, 1'b0, 0, 0);
      run_frame(5120, 1'b1, 0, 0);

      run_frame(10, 1'b0, 0, 3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("midframe_reset");
      sbq.delete();
      rst_n = 1'b1;
      run_frame(2, 1'b0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
